// File: rtl/upscale_stream_tx_16_if.sv
// Handshake bundle of the softmax output stage: fixed-point input stream plus AXI4-Stream fp32 output.
// The master modport is the block's view; the slave modport is the view of the surrounding datapath.
interface upscale_stream_tx_16_if #(
    parameter int data_size = 16
);
    logic                     in_valid_i;
    logic [data_size-1:0]     in_data_i;
    logic [7:0]               in_number_of_data_i;
    logic                     in_ready_o;
    logic                     m_axis_valid_o;
    logic [2*data_size-1:0]   m_axis_data_o;
    logic                     m_axis_last_o;
    logic                     m_axis_ready_i;

    modport master (
        input  in_valid_i, in_data_i, in_number_of_data_i, m_axis_ready_i,
        output in_ready_o, m_axis_valid_o, m_axis_data_o, m_axis_last_o
    );

    modport slave (
        output in_valid_i, in_data_i, in_number_of_data_i, m_axis_ready_i,
        input  in_ready_o, m_axis_valid_o, m_axis_data_o, m_axis_last_o
    );
endinterface

// File: rtl/upscale_stream_tx_16.sv
// Buffers a frame of signed 1.7.8 values, converts each exactly to fp32 and sends it
// on an AXI4-Stream master with last on the final beat and a done pulse per frame.
module upscale_stream_tx_16 #(
    parameter int data_size  = 16,
    parameter int fifo_depth = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    upscale_stream_tx_16_if.master bus,
    output logic                  tx_done_o
);
    localparam int ptr_w = $clog2(fifo_depth);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r, state_next_s;
    logic [data_size-1:0]   mem_r [fifo_depth];
    logic [ptr_w-1:0]       wr_ptr_r, rd_ptr_r;
    logic [ptr_w:0]         count_r;
    logic [7:0]             frame_len_r, in_cnt_r, out_cnt_r;
    logic                   active_r, done_r;
    logic                   out_valid_r, out_last_r;
    logic [2*data_size-1:0] out_data_r;
    logic                   fifo_full_s, fifo_empty_s;
    logic                   in_ready_s, push_s, load_s, out_fire_s;

    // 1.7.8 value d is d/256; leading one at p gives exponent 127 + p - 8
    function automatic logic [31:0] fx_to_fp32(input logic [15:0] d);
        logic [15:0] mag;
        logic [3:0]  p;
        logic [23:0] sh;
        logic [31:0] r;
        mag = d[15] ? (~d + 16'd1) : d;
        p   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mag[i]) begin
                p = 4'(i);
            end
        end
        sh = {8'd0, mag} << (5'd23 - {1'b0, p});
        if (mag == 16'd0) begin
            r = 32'd0;
        end else begin
            r = {d[15], 8'd119 + {4'd0, p}, sh[22:0]};
        end
        return r;
    endfunction

    assign fifo_full_s  = (count_r == (ptr_w + 1)'(fifo_depth));
    assign fifo_empty_s = (count_r == '0);
    assign push_s       = bus.in_valid_i & in_ready_s;
    assign out_fire_s   = out_valid_r & bus.m_axis_ready_i;
    assign load_s       = (state_r == RUN) & (~out_valid_r | bus.m_axis_ready_i)
                        & ~fifo_empty_s & (out_cnt_r < frame_len_r);

    assign bus.in_ready_o     = in_ready_s;
    assign bus.m_axis_valid_o = out_valid_r;
    assign bus.m_axis_data_o  = out_data_r;
    assign bus.m_axis_last_o  = out_last_r;
    assign tx_done_o          = done_r;

    // Input acceptance; held off for the first cycle out of reset
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = active_r & ~fifo_full_s & (bus.in_number_of_data_i != 8'd0);
            RUN:     in_ready_s = ~fifo_full_s & (in_cnt_r < frame_len_r);
            DONE:    in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Frame sequencing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (push_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (out_fire_s & out_last_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered done pulse
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            done_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            done_r   <= (state_next_s == DONE);
            active_r <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clock_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, load_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame length and beat counters; cleared on the way back to IDLE
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            frame_len_r <= 8'd0;
            in_cnt_r    <= 8'd0;
            out_cnt_r   <= 8'd0;
        end else if (state_r == DONE) begin
            in_cnt_r  <= 8'd0;
            out_cnt_r <= 8'd0;
        end else begin
            if (push_s && state_r == IDLE) begin
                frame_len_r <= bus.in_number_of_data_i;
                in_cnt_r    <= 8'd1;
            end else if (push_s) begin
                in_cnt_r <= in_cnt_r + 8'd1;
            end
            if (load_s) begin
                out_cnt_r <= out_cnt_r + 8'd1;
            end
        end
    end

    // Output register: load on free slot, drop after handshake, otherwise hold
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= (out_cnt_r == frame_len_r - 8'd1);
            out_data_r  <= fx_to_fp32(mem_r[rd_ptr_r]);
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end
endmodule
